// File: rtl/uart_rx_ctrl.sv
// UART receiver control: enable FSM with frame-error holdoff, show-ahead byte FIFO,
// sticky status flags and a saturating error counter, all in the 16x oversample domain.
module uart_rx_ctrl #(
  parameter int DEPTH   = 8,
  parameter int HOLDOFF = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  input  logic                     rx_busy,
  input  logic                     rx_err,
  output logic                     rx_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overrun,
  output logic                     frame_err,
  output logic [7:0]               err_count,
  input  logic                     clr_status,
  output logic                     active
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {DISABLED, ARMED, RECOVER} state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic            rx_err_d;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic            armed;
  logic            err_evt;
  logic            push_req;
  logic            pop;
  logic            full;
  logic            push;
  logic            drop;
  logic [CW-1:0]   cnt_next;
  logic [PW-1:0]   rd_ptr_inc;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    armed      = (state == ARMED);
    err_evt    = armed && rx_err && !rx_err_d;
    push_req   = armed && rx_done;
    pop        = rd_valid && rd_ready;
    full       = (fifo_count == CW'(DEPTH));
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    push       = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    rd_ptr_inc = rd_ptr + PW'(1);
    cnt_next   = fifo_count;
    if (push && !pop)
      cnt_next = fifo_count + CW'(1);
    else if (pop && !push)
      cnt_next = fifo_count - CW'(1);
  end

  // Control FSM and receiver enable
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DISABLED;
      rx_en    <= 1'b0;
      hold_cnt <= '0;
      rx_err_d <= 1'b0;
      active   <= 1'b0;
    end else begin
      rx_err_d <= rx_err;
      active   <= armed && rx_busy;
      case (state)
        DISABLED: begin
          if (enable) begin
            state <= ARMED;
            rx_en <= 1'b1;
          end
        end
        ARMED: begin
          if (err_evt) begin
            state    <= RECOVER;
            rx_en    <= 1'b0;
            hold_cnt <= HW'(HOLDOFF - 1);
          end else if (!enable) begin
            state <= DISABLED;
            rx_en <= 1'b0;
          end
        end
        RECOVER: begin
          if (hold_cnt == '0) begin
            state <= enable ? ARMED : DISABLED;
            rx_en <= enable;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: begin
          state <= DISABLED;
          rx_en <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and show-ahead head register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      fifo_count <= cnt_next;
      rd_valid   <= (cnt_next != '0);
      if (pop) begin
        if (fifo_count > CW'(1))
          rd_data <= mem[rd_ptr_inc];
        else if (push)
          rd_data <= rx_data;
      end else if (push && fifo_count == '0) begin
        rd_data <= rx_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  // Sticky status; a set event in the same cycle as clr_status wins
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      err_count <= 8'h00;
    end else begin
      if (drop)            overrun <= 1'b1;
      else if (clr_status) overrun <= 1'b0;
      if (err_evt)         frame_err <= 1'b1;
      else if (clr_status) frame_err <= 1'b0;
      if (clr_status)      err_count <= err_evt ? 8'h01 : 8'h00;
      else if (err_evt)    err_count <= sat_inc8(err_count);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: vector table for FIFO behaviour plus
// hand sequences for frame-error holdoff, counter saturation and reset.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       rx_err;
  logic       rx_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] fifo_count;
  logic       overrun;
  logic       frame_err;
  logic [7:0] err_count;
  logic       clr_status;
  logic       active;

  int checks = 0;
  int errors = 0;

  uart_rx_ctrl #(.DEPTH(8), .HOLDOFF(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rx_data(rx_data), .rx_done(rx_done),
    .rx_busy(rx_busy), .rx_err(rx_err), .rx_en(rx_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .fifo_count(fifo_count),
    .overrun(overrun), .frame_err(frame_err), .err_count(err_count),
    .clr_status(clr_status), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       done;
    logic [7:0] data;
    logic       rdy;
    logic       clr;
    logic       x_rx_en;
    logic       x_valid;
    logic [7:0] x_data;
    int         x_cnt;
    logic       x_ovr;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(logic en, logic done, logic [7:0] data, logic rdy, logic clr,
                              logic x_rx_en, logic x_valid, logic [7:0] x_data,
                              int x_cnt, logic x_ovr);
    vec_t v;
    v.en = en; v.done = done; v.data = data; v.rdy = rdy; v.clr = clr;
    v.x_rx_en = x_rx_en; v.x_valid = x_valid; v.x_data = x_data;
    v.x_cnt = x_cnt; v.x_ovr = x_ovr;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx_en_high(input string name);
    int n = 0;
    while (rx_en !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(name, int'(rx_en === 1'b1), 1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " rx_en"}, int'(rx_en), 0);
    chk({tag, " rd_valid"}, int'(rd_valid), 0);
    chk({tag, " rd_data"}, int'(rd_data), 0);
    chk({tag, " fifo_count"}, int'(fifo_count), 0);
    chk({tag, " overrun"}, int'(overrun), 0);
    chk({tag, " frame_err"}, int'(frame_err), 0);
    chk({tag, " err_count"}, int'(err_count), 0);
    chk({tag, " active"}, int'(active), 0);
  endtask

  initial begin
    int lowcnt;
    int n;

    rst = 1'b1; enable = 1'b0; rx_data = 8'h00; rx_done = 1'b0; rx_busy = 1'b0;
    rx_err = 1'b0; rd_ready = 1'b0; clr_status = 1'b0;

    //            en done data  rdy clr  rx_en vld  rdat  cnt ovr
    tbl[0]  = mk(1, 0, 8'h00, 0, 0,   1, 0, 8'h00, 0, 0);
    tbl[1]  = mk(1, 1, 8'hA5, 0, 0,   1, 1, 8'hA5, 1, 0);
    tbl[2]  = mk(1, 0, 8'h00, 1, 0,   1, 0, 8'hA5, 0, 0);
    for (int i = 0; i < 8; i++)
      tbl[3+i] = mk(1, 1, 8'(i + 1), 0, 0, 1, 1, 8'h01, i + 1, 0);
    tbl[11] = mk(1, 1, 8'h09, 0, 0,   1, 1, 8'h01, 8, 1);
    tbl[12] = mk(1, 0, 8'h00, 0, 1,   1, 1, 8'h01, 8, 0);
    tbl[13] = mk(1, 1, 8'h0A, 1, 0,   1, 1, 8'h02, 8, 0);
    for (int i = 0; i < 6; i++)
      tbl[14+i] = mk(1, 0, 8'h00, 1, 0, 1, 1, 8'(i + 3), 7 - i, 0);
    tbl[20] = mk(1, 0, 8'h00, 1, 0,   1, 1, 8'h0A, 1, 0);
    tbl[21] = mk(1, 0, 8'h00, 1, 0,   1, 0, 8'h0A, 0, 0);
    tbl[22] = mk(1, 1, 8'h5C, 1, 0,   1, 1, 8'h5C, 1, 0);
    tbl[23] = mk(1, 0, 8'h00, 1, 0,   1, 0, 8'h5C, 0, 0);

    step(); step();
    rst = 1'b0;
    chk_reset_state("reset");

    for (int i = 0; i < 24; i++) begin
      enable = tbl[i].en; rx_done = tbl[i].done; rx_data = tbl[i].data;
      rd_ready = tbl[i].rdy; clr_status = tbl[i].clr;
      step();
      chk($sformatf("v%0d rx_en", i), int'(rx_en), int'(tbl[i].x_rx_en));
      chk($sformatf("v%0d rd_valid", i), int'(rd_valid), int'(tbl[i].x_valid));
      if (tbl[i].x_valid || i == 21 || i == 23)
        chk($sformatf("v%0d rd_data", i), int'(rd_data), int'(tbl[i].x_data));
      chk($sformatf("v%0d fifo_count", i), int'(fifo_count), tbl[i].x_cnt);
      chk($sformatf("v%0d overrun", i), int'(overrun), int'(tbl[i].x_ovr));
    end
    rx_done = 1'b0; rd_ready = 1'b0; clr_status = 1'b0;

    // active follows rx_busy while armed
    rx_busy = 1'b1;
    step();
    chk("active busy", int'(active), 1);
    rx_busy = 1'b0;
    step();
    chk("active idle", int'(active), 0);

    // Frame error: 16-cycle holdoff, rx_done ignored during it
    rx_err = 1'b1;
    step();
    rx_err = 1'b0;
    chk("ferr frame_err", int'(frame_err), 1);
    chk("ferr err_count", int'(err_count), 1);
    rx_done = 1'b1; rx_data = 8'h77;
    lowcnt = 0;
    n = 0;
    while (rx_en == 1'b0 && n < 40) begin
      lowcnt++;
      step();
      rx_done = 1'b0;
      n++;
    end
    chk("holdoff low cycles", lowcnt, 16);
    chk("holdoff rx_en back", int'(rx_en), 1);
    chk("holdoff push ignored", int'(fifo_count), 0);

    // 256 more error edges saturate the counter
    for (int i = 0; i < 256; i++) begin
      rx_err = 1'b1;
      step();
      rx_err = 1'b0;
      wait_rx_en_high($sformatf("sat wait %0d", i));
    end
    chk("sat err_count", int'(err_count), 255);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("clr err_count", int'(err_count), 0);
    chk("clr frame_err", int'(frame_err), 0);
    clr_status = 1'b1; rx_err = 1'b1;
    step();
    clr_status = 1'b0; rx_err = 1'b0;
    chk("clr+edge frame_err", int'(frame_err), 1);
    chk("clr+edge err_count", int'(err_count), 1);
    wait_rx_en_high("clr+edge recover");

    // Disable with bytes buffered: contents stay readable
    for (int i = 0; i < 3; i++) begin
      rx_done = 1'b1; rx_data = 8'(8'hB1 + i);
      step();
    end
    rx_done = 1'b0; enable = 1'b0;
    step();
    chk("dis rx_en", int'(rx_en), 0);
    chk("dis fifo_count", int'(fifo_count), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dis read %0d", i), int'(rd_data), 8'hB1 + i);
      rd_ready = 1'b1;
      step();
    end
    rd_ready = 1'b0;
    chk("dis drained", int'(rd_valid), 0);

    // Reset in the middle of RECOVER
    enable = 1'b1;
    step();
    chk("reenable rx_en", int'(rx_en), 1);
    rx_done = 1'b1; rx_data = 8'h3C;
    step();
    rx_done = 1'b0;
    rx_err = 1'b1;
    step();
    rx_err = 1'b0;
    step(); step(); step();
    chk("pre-rst rx_en", int'(rx_en), 0);
    chk("pre-rst fifo_count", int'(fifo_count), 1);
    rst = 1'b1;
    step();
    chk_reset_state("mid-recover rst");
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
